// File: rtl/ser_collector_pkg.sv
// Shared constants and types for the serial word collector.
// Default word width and FIFO depth, the collector FSM state encoding and
// the width of the optional dropped-word counter (SER_COLLECTOR_DROP_CNT_EN).
package ser_collector_pkg;

    localparam int SC_WIDTH  = 8;
    localparam int SC_DEPTH  = 4;
    localparam int SC_DROP_W = 8;

    typedef enum logic {
        SC_IDLE  = 1'b0,
        SC_SHIFT = 1'b1
    } sc_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO built from flops.
// The head entry is presented combinationally on dout; full, empty and level
// come straight from registered state, so rd_en never reaches them
// combinationally. A push that arrives while full and without a same-edge
// pop is discarded and reported on drop.
module sync_fifo
    import ser_collector_pkg::*;
#(
    parameter int WIDTH = SC_WIDTH,
    parameter int DEPTH = SC_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [LW-1:0]    level,
    output logic             drop
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees a slot on the same edge, so a push into a full FIFO still
    // succeeds when it coincides with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    // Next-state for pointers and fill level.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage: each entry is its own resettable register so dout reads zero
    // out of reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture din into this entry when it is the write target.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mem_q[gi] <= '0;
                end else if (do_push && (wr_ptr_q == AW'(gi))) begin
                    mem_q[gi] <= din;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/ser_word_collector.sv
// Serial-to-parallel word collector behind the 110101 sequence detector.
// Bits are accepted when clk_en and ser_in_valid are both high, packed
// MSB-first into WIDTH-bit words, and completed words are queued in a FWFT
// FIFO. overflow is a sticky flag for dropped words. Defining
// SER_COLLECTOR_DROP_CNT_EN adds a saturating dropped-word counter on drop_cnt.
module ser_word_collector
    import ser_collector_pkg::*;
#(
    parameter int WIDTH = SC_WIDTH,
    parameter int DEPTH = SC_DEPTH,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 ser_in,
    input  logic                 ser_in_valid,
    input  logic                 flush,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    output logic                 full,
    output logic [LW-1:0]        level,
`ifdef SER_COLLECTOR_DROP_CNT_EN
    output logic [SC_DROP_W-1:0] drop_cnt,
`endif
    output logic                 overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int SH_W  = WIDTH - 1;

    // Only WIDTH-1 bits are ever held: the WIDTH-th bit completes the word
    // and goes straight into the FIFO together with the held bits.
    sc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SH_W-1:0]  shreg_q, shreg_d;
    logic             acc;
    logic             word_push;
    logic [WIDTH-1:0] word;
    logic             fifo_empty;
    logic             fifo_drop;
    logic             overflow_q;

    assign acc  = clk_en & ser_in_valid;
    assign word = {shreg_q, ser_in};

    // Collector FSM, bit counter and shifter; flush beats a same-edge accept.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        word_push = 1'b0;
        if (flush) begin
            state_d = SC_IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end else if (acc) begin
            if ((state_q == SC_SHIFT) && (cnt_q == CNT_W'(WIDTH - 1))) begin
                word_push = 1'b1;
                state_d   = SC_IDLE;
                cnt_d     = '0;
                shreg_d   = '0;
            end else begin
                state_d = SC_SHIFT;
                cnt_d   = cnt_q + CNT_W'(1);
                shreg_d = SH_W'({shreg_q, ser_in});
            end
        end
    end

    // Collector state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SC_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Sticky overflow: set by any dropped word, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else if (fifo_drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow   = overflow_q;
    assign dout_valid = ~fifo_empty;

`ifdef SER_COLLECTOR_DROP_CNT_EN
    logic [SC_DROP_W-1:0] drop_cnt_q;

    // Dropped-word counter, saturating at its maximum value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else if (fifo_drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + SC_DROP_W'(1);
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (word_push),
        .din   (word),
        .pop   (rd_en),
        .dout  (dout),
        .empty (fifo_empty),
        .full  (full),
        .level (level),
        .drop  (fifo_drop)
    );

endmodule
